// File: rtl/hs_write_sink.sv
// -----------------------------------------------------------------------------
// hs_write_sink
//
// Purpose:
//   Terminating follower for a four-phase rw/aw write handshake, as driven by
//   the output of a single-stage FIFO chain. Each offered byte is captured into
//   a small circular buffer, the handshake is completed, and buffered bytes are
//   presented toward consumer logic on a valid/ready stream. When the buffer is
//   full and the consumer is not popping, the ack is withheld. That leaves rw
//   pending and stalls the whole upstream chain.
//
// Parameters:
//   WIDTH   data width in bits (matches the chain data width)
//   DEPTH   buffer entries, power of two, >= 2
//   AW_CNT  width of the occupancy output, must hold 0..DEPTH
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   din     in   write data from the upstream initiator, valid while rw=1
//   rw      in   write request from the upstream initiator
//   aw      out  write acknowledge to the upstream initiator (registered)
//   dout    out  head-of-buffer data (0 while the buffer is empty)
//   dvalid  out  buffer non-empty, dout valid
//   dready  in   consumer accepts dout when dvalid=1
//   count   out  current buffer occupancy
//   err     out  sticky protocol error flag
//
// Build option:
//   HS_SINK_PROTO_CHECK_EN  when defined, err latches (until reset) on either
//                           of two initiator violations seen while a request is
//                           stalled by a full buffer: din changes, or rw is
//                           withdrawn before the ack. When undefined, err is
//                           tied to 0 and no checker logic exists. Handshake
//                           behaviour is identical in both builds.
// -----------------------------------------------------------------------------
module hs_write_sink #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int AW_CNT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  din,
    input  logic              rw,
    output logic              aw,
    output logic [WIDTH-1:0]  dout,
    output logic              dvalid,
    input  logic              dready,
    output logic [AW_CNT-1:0] count,
    output logic              err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;
    logic             space;
    logic             push;

    // Occupancy update. A push into a full buffer is only possible together
    // with a pop, so the count can neither overflow nor underflow.
    function automatic logic [AW_CNT-1:0] next_count(
        input logic [AW_CNT-1:0] c,
        input logic              inc,
        input logic              dec
    );
        case ({inc, dec})
            2'b10:   return c + AW_CNT'(1);
            2'b01:   return c - AW_CNT'(1);
            default: return c;
        endcase
    endfunction

    // Read side. Full/empty come from count, because the pointers alone are
    // ambiguous when they are equal.
    assign dvalid = (count != '0);
    assign pop    = dvalid && dready;

    // A full buffer that is popping in the same cycle still has room. The
    // outgoing head slot is read this cycle and freed by the same edge.
    assign space  = (count < AW_CNT'(DEPTH)) || pop;
    assign push   = (state == IDLE) && rw && space;

    // Storage is uninitialised after reset, so the output is gated by dvalid.
    // That gating gives the zero value shown while the buffer is empty.
    assign dout   = dvalid ? mem[rd_ptr] : '0;

    // Handshake FSM, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            aw     <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // rw stays pending while there is no space. The missing
                    // ack is the backpressure seen by the chain.
                    if (push) begin
                        state  <= ACK;
                        aw     <= 1'b1;
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                end
                ACK: begin
                    // rw held high keeps the ack up without capturing again.
                    if (!rw) begin
                        state <= IDLE;
                        aw    <= 1'b0;
                    end
                end
            endcase
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= next_count(count, push, pop);
        end
    end

    // Buffer storage (data only, not reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

`ifdef HS_SINK_PROTO_CHECK_EN
    logic             stall;
    logic             stall_q;
    logic [WIDTH-1:0] din_q;

    // A request that could not be captured at this edge.
    assign stall = (state == IDLE) && rw && !space;

    // Protocol checker. Once a request has stalled, the initiator must hold
    // din and keep rw high until the ack arrives.
    always_ff @(posedge clk) begin
        din_q <= din;
        if (reset) begin
            stall_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            stall_q <= stall;
            if (stall_q && (state == IDLE) && (!rw || (din != din_q))) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_write_sink.sv
// -----------------------------------------------------------------------------
// tb_hs_write_sink
//
// Self-checking bench for hs_write_sink. A queue-based reference model tracks
// the bytes the sink holds and whether the ack is up. After every clock the
// DUT outputs are compared against it. Directed scenarios come first, followed
// by a randomized initiator/consumer phase. The err expectation follows
// HS_SINK_PROTO_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_hs_write_sink;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int AW_CNT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  din;
    logic              rw;
    logic              aw;
    logic [WIDTH-1:0]  dout;
    logic              dvalid;
    logic              dready;
    logic [AW_CNT-1:0] count;
    logic              err;

    always #5 clk = ~clk;

    hs_write_sink #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW_CNT(AW_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .rw    (rw),
        .aw    (aw),
        .dout  (dout),
        .dvalid(dvalid),
        .dready(dready),
        .count (count),
        .err   (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: bytes held in the sink, ack state, error state
    logic [7:0] mq[$];
    bit         mack;
    bit         m_err;
    bit         m_stall;
    logic [7:0] m_din_prev;

    // Observed output stream and peak occupancy
    logic [7:0] out_log[$];
    int         max_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance the model across one clock edge using the current inputs, then
    // compare every DUT output against it.
    task automatic cycle();
        bit pop;
        bit acc;
        bit idle;
        idle = !mack;
        pop  = (mq.size() != 0) && dready;
        acc  = idle && rw && ((mq.size() < DEPTH) || pop);
        if (dvalid === 1'b1 && dready === 1'b1) out_log.push_back(dout);
        if (reset) begin
            mq.delete();
            mack    = 1'b0;
            m_err   = 1'b0;
            m_stall = 1'b0;
        end else begin
`ifdef HS_SINK_PROTO_CHECK_EN
            if (m_stall && idle && (!rw || din !== m_din_prev)) m_err = 1'b1;
`endif
            m_stall    = idle && rw && !acc;
            m_din_prev = din;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(din);
                mack = 1'b1;
            end else if (mack && !rw) begin
                mack = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        chk("aw",     32'(aw),     32'(mack));
        chk("dvalid", 32'(dvalid), 32'(mq.size() != 0));
        chk("count",  32'(count),  32'(mq.size()));
        chk("dout",   32'(dout),   32'((mq.size() != 0) ? mq[0] : 8'h00));
        chk("err",    32'(err),    32'(m_err));
    endtask

    // One complete four-phase transfer, with a bounded wait for the ack
    task automatic send(input logic [7:0] b);
        int t;
        din = b;
        rw  = 1'b1;
        t   = 0;
        do begin
            cycle();
            t++;
        end while (aw !== 1'b1 && t < 20);
        chk("send_ack", 32'(aw), 32'd1);
        rw = 1'b0;
        cycle();
    endtask

    task automatic drain();
        dready = 1'b1;
        repeat (DEPTH + 1) cycle();
        dready = 1'b0;
    endtask

    initial begin
        bit exp_err;
        reset = 1'b1;
        rw = 1'b0;
        din = '0;
        dready = 1'b0;
        max_cnt = 0;
        cycle();
        chk("rst_aw",    32'(aw),     32'd0);
        chk("rst_cnt",   32'(count),  32'd0);
        chk("rst_dvld",  32'(dvalid), 32'd0);
        chk("rst_dout",  32'(dout),   32'd0);
        chk("rst_err",   32'(err),    32'd0);
        reset = 1'b0;
        cycle();

        // Single handshake
        din = 8'hA5;
        rw  = 1'b1;
        cycle();
        chk("t1_aw",   32'(aw),     32'd1);
        chk("t1_dvld", 32'(dvalid), 32'd1);
        chk("t1_dout", 32'(dout),   32'hA5);
        chk("t1_cnt",  32'(count),  32'd1);
        rw = 1'b0;
        cycle();
        chk("t1_awdn", 32'(aw), 32'd0);
        drain();

        // Fill with no consumer, fifth request stalls, then pop and push together
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("t2_full", 32'(count), 32'd4);
        din = 8'h05;
        rw  = 1'b1;
        repeat (6) begin
            cycle();
            chk("t2_stall_aw", 32'(aw), 32'd0);
        end
        dready = 1'b1;
        cycle();
        dready = 1'b0;
        chk("t2_pp_aw",   32'(aw),    32'd1);
        chk("t2_pp_cnt",  32'(count), 32'd4);
        chk("t2_pp_head", 32'(dout),  32'h02);
        rw = 1'b0;
        cycle();
        drain();

        // Back-to-back stream with the consumer always ready
        out_log.delete();
        max_cnt = 0;
        dready  = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
        repeat (2) cycle();
        dready = 1'b0;
        chk("t3_len",    32'(out_log.size()), 32'd16);
        chk("t3_maxcnt", 32'(max_cnt),        32'd1);
        for (int i = 0; i < 16 && i < out_log.size(); i++)
            chk("t3_order", 32'(out_log[i]), 32'(8'h10 + i));

        // Reset while in ACK with two entries held
        send(8'h3A);
        din = 8'h3B;
        rw  = 1'b1;
        cycle();
        chk("t4_pre_aw",  32'(aw),    32'd1);
        chk("t4_pre_cnt", 32'(count), 32'd2);
        reset = 1'b1;
        rw    = 1'b0;
        cycle();
        reset = 1'b0;
        chk("t4_aw",   32'(aw),     32'd0);
        chk("t4_dvld", 32'(dvalid), 32'd0);
        chk("t4_cnt",  32'(count),  32'd0);
        send(8'h3C);
        chk("t4_dout", 32'(dout),  32'h3C);
        chk("t4_cnt1", 32'(count), 32'd1);
        drain();

        // rw held high long after the ack gives a single capture
        din = 8'h77;
        rw  = 1'b1;
        cycle();
        repeat (10) cycle();
        chk("t5_cnt", 32'(count), 32'd1);
        chk("t5_aw",  32'(aw),    32'd1);
        rw = 1'b0;
        cycle();
        drain();

        // din changes while a request is stalled on a full buffer
        for (int i = 0; i < 4; i++) send(8'(8'h50 + i));
        din = 8'h11;
        rw  = 1'b1;
        repeat (2) cycle();
        din = 8'h22;
        repeat (3) cycle();
`ifdef HS_SINK_PROTO_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        chk("t6_err", 32'(err), 32'(exp_err));
        reset = 1'b1;
        rw    = 1'b0;
        cycle();
        reset = 1'b0;
        chk("t6_err_clr", 32'(err), 32'd0);

        // Randomized initiator and consumer
        for (int c = 0; c < 2000; c++) begin
            if (!rw && aw === 1'b0 && $urandom_range(0, 2) == 0) begin
                din = 8'($urandom);
                rw  = 1'b1;
            end else if (rw && aw === 1'b1 && $urandom_range(0, 1) == 0) begin
                rw = 1'b0;
            end
            dready = 1'($urandom_range(0, 3) == 0);
            cycle();
        end
        rw = 1'b0;
        cycle();
        drain();
        chk("end_empty", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
